per2apb_bridge: RTL and testbench
=================================

// Module: per2apb_bridge
// PURPOSE
//  Initiator-side bridge: accepts single-beat peripheral-interconnect requests (req/gnt + r_valid) and
//  issues them as APB3 master transfers (APB4 PSTRB also driven). Lets a peripheral-bus master
//  (FC core, HWPE event/cfg path) reach APB-only slaves such as accelerator config ports.
//  One transfer in flight at a time; the response is returned with the requester's ID.
// PARAMETERS
//  APB_ADDR_WIDTH  32   PADDR width; per_slave_add_i[APB_ADDR_WIDTH-1:0] is forwarded, upper bits dropped
//  ID_WIDTH        8    request/response ID width
//  TIMEOUT_CYCLES  255  ACCESS-phase wait limit (used only with PER2APB_TIMEOUT_EN)
// PORTS
//  clk_i              in   1               clock
//  rst_ni             in   1               reset, synchronous, active-low
//  per_slave_req_i    in   1               request valid
//  per_slave_add_i    in   32              byte address
//  per_slave_we_i     in   1               1 = write, 0 = read
//  per_slave_wdata_i  in   32              write data
//  per_slave_be_i     in   4               byte enables
//  per_slave_id_i     in   ID_WIDTH        requester ID
//  per_slave_gnt_o    out  1               grant (combinational)
//  per_slave_r_valid_o out 1               response valid, one-cycle pulse
//  per_slave_r_opc_o  out  1               0 = OK, 1 = error
//  per_slave_r_rdata_o out 32              read data
//  per_slave_r_id_o   out  ID_WIDTH        ID of the granted request
//  paddr_o            out  APB_ADDR_WIDTH  APB address
//  pwdata_o / pwrite_o / pstrb_o  out  32 / 1 / 4  APB write data / direction / strobes
//  psel_o / penable_o out  1 / 1           APB select / enable
//  prdata_i / pready_i / pslverr_i  in  32 / 1 / 1  APB response
// BEHAVIOUR
//  - Reset (rst_ni low at a clock edge): state <= IDLE; psel_o, penable_o, pwrite_o, r_valid_o, r_opc_o = 0;
//    paddr_o, pwdata_o, pstrb_o, r_rdata_o, r_id_o = 0. gnt_o is forced to 0 while rst_ni is low.
//  - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//  - IDLE: gnt_o = req_i. On req_i & gnt_o, register add/wdata/we/id; pstrb_o <= we ? be : 4'b0.
//    Next state is SETUP. gnt_o = 0 in every other state.
//  - SETUP: psel_o = 1, penable_o = 0. All APB outputs are stable from SETUP until ACCESS completes.
//  - ACCESS: psel_o = 1, penable_o = 1. Stay while pready_i = 0. When pready_i = 1: capture
//    rdata <= we ? 32'h0 : prdata_i and opc <= pslverr_i, then go to RESP.
//    psel_o and penable_o drop to 0 on the next cycle.
//  - RESP: r_valid_o = 1 for exactly one cycle, with r_rdata_o / r_opc_o / r_id_o. Then IDLE.
//  - Minimum latency: gnt at cycle 0, SETUP at 1, ACCESS at 2 (pready=1), r_valid at 3.
//    Peak throughput: one transfer per 4 cycles.
//  - A request arriving during SETUP/ACCESS/RESP is held off by gnt_o = 0. The requester
//    must hold req_i and its payload stable until granted.
//  - Back-to-back: a request present in the cycle after RESP is granted in that IDLE cycle.
//  - Reset during SETUP/ACCESS: APB signals drop at the reset edge. The aborted transfer
//    produces no r_valid.
//  - The r_valid path has no back-pressure; the requester must always accept a response.
// CONFIGURATION
//  - `PER2APB_TIMEOUT_EN defined:
//    - A counter clears on entry to ACCESS and increments on each ACCESS cycle with pready_i = 0.
//    - When the count reaches TIMEOUT_CYCLES with pready_i still 0, the transfer is abandoned:
//      psel_o/penable_o drop, state goes to RESP with r_opc_o = 1 and r_rdata_o = 32'h0BAD_ACCE.
//    - pready_i = 1 in the same cycle the limit is reached wins: normal completion.
//  - Not defined: no counter; ACCESS waits indefinitely; TIMEOUT_CYCLES is unused.
// STRUCTURE
//  - per2apb_pkg: state_e enum {IDLE, SETUP, ACCESS, RESP}; OPC_OK = 1'b0, OPC_ERR = 1'b1;
//    TIMEOUT_RDATA = 32'h0BAD_ACCE.
//  - Single module; the timeout counter is inline under the ifdef. No sub-module.
// TESTING
//  1. Write: add=0x1A10_2004, wdata=0xCAFE_F00D, be=4'hF, id=8'h3C, pready=1 immediately ->
//     gnt at cycle 0; psel=1/penable=0 at 1; psel=1/penable=1, pwrite=1, pstrb=F at 2;
//     r_valid at 3 with r_opc=0, r_rdata=0, r_id=3C.
//  2. Read: pready held low 5 cycles, then prdata=0x1234_5678 ->
//     penable held high 6 cycles with paddr stable; r_rdata=0x1234_5678, r_opc=0.
//  3. Read with pslverr=1 on completion -> r_opc=1; pstrb=0 throughout.
//  4. Second req asserted during ACCESS of the first -> gnt stays 0 until the IDLE cycle after
//     the first RESP; the second r_id is correct; no overlap of psel between transfers.
//  5. rst_ni low for 1 cycle mid-ACCESS -> psel/penable = 0 the next cycle; no r_valid;
//     the next request completes normally.
//  6. `PER2APB_TIMEOUT_EN with TIMEOUT_CYCLES=4 and pready stuck low -> response after 4 wait
//     cycles with r_opc=1, r_rdata=0x0BAD_ACCE.
//     Without the macro -> no response within 1000 cycles.

Source files
------------

// File: rtl/per2apb_pkg.sv
// Shared types and constants for the peripheral-interconnect to APB bridge.
package per2apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam logic        OPC_OK        = 1'b0;
    localparam logic        OPC_ERR       = 1'b1;
    localparam logic [31:0] TIMEOUT_RDATA = 32'h0BAD_ACCE;

endpackage

// File: rtl/per2apb_bridge.sv
// Single-outstanding bridge from peripheral-interconnect requests to APB3/APB4 master transfers.
// Optional ACCESS-phase watchdog enabled by defining PER2APB_TIMEOUT_EN.
module per2apb_bridge
    import per2apb_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned ID_WIDTH       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      per_slave_req_i,
    input  logic [31:0]               per_slave_add_i,
    input  logic                      per_slave_we_i,
    input  logic [31:0]               per_slave_wdata_i,
    input  logic [3:0]                per_slave_be_i,
    input  logic [ID_WIDTH-1:0]       per_slave_id_i,
    output logic                      per_slave_gnt_o,
    output logic                      per_slave_r_valid_o,
    output logic                      per_slave_r_opc_o,
    output logic [31:0]               per_slave_r_rdata_o,
    output logic [ID_WIDTH-1:0]       per_slave_r_id_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [31:0]               pwdata_o,
    output logic                      pwrite_o,
    output logic [3:0]                pstrb_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [31:0]               prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    state_e                    r_state;
    logic [APB_ADDR_WIDTH-1:0] r_paddr;
    logic [31:0]               r_pwdata;
    logic                      r_pwrite;
    logic [3:0]                r_pstrb;
    logic [ID_WIDTH-1:0]       r_id;
    logic [31:0]               r_rdata;
    logic                      r_opc;
    logic                      w_gnt;
    logic                      w_abort;

    assign w_gnt = rst_ni && (r_state == IDLE) && per_slave_req_i;

`ifdef PER2APB_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_wait_cnt;

    // Abandon on the wait cycle that would bring the count up to the limit.
    assign w_abort = (r_state == ACCESS) && !pready_i &&
                     (({1'b0, r_wait_cnt} + 1'b1) == (CNT_W + 1)'(TIMEOUT_CYCLES));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_wait_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_wait_cnt <= '0;
        end else if ((r_state == ACCESS) && !pready_i) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end
`else
    assign w_abort = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state  <= IDLE;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
            r_pstrb  <= '0;
            r_id     <= '0;
            r_rdata  <= '0;
            r_opc    <= OPC_OK;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt) begin
                        r_paddr  <= per_slave_add_i[APB_ADDR_WIDTH-1:0];
                        r_pwdata <= per_slave_wdata_i;
                        r_pwrite <= per_slave_we_i;
                        r_pstrb  <= per_slave_we_i ? per_slave_be_i : 4'b0;
                        r_id     <= per_slave_id_i;
                        r_state  <= SETUP;
                    end
                end
                SETUP: begin
                    r_state <= ACCESS;
                end
                ACCESS: begin
                    if (pready_i) begin
                        r_rdata <= r_pwrite ? 32'h0 : prdata_i;
                        r_opc   <= pslverr_i;
                        r_state <= RESP;
                    end else if (w_abort) begin
                        r_rdata <= TIMEOUT_RDATA;
                        r_opc   <= OPC_ERR;
                        r_state <= RESP;
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // APB phase strobes and the response pulse are pure state decodes.
    assign psel_o              = (r_state == SETUP) || (r_state == ACCESS);
    assign penable_o           = (r_state == ACCESS);
    assign per_slave_r_valid_o = (r_state == RESP);

    assign per_slave_gnt_o     = w_gnt;
    assign per_slave_r_opc_o   = r_opc;
    assign per_slave_r_rdata_o = r_rdata;
    assign per_slave_r_id_o    = r_id;
    assign paddr_o             = r_paddr;
    assign pwdata_o            = r_pwdata;
    assign pwrite_o            = r_pwrite;
    assign pstrb_o             = r_pstrb;

endmodule

// File: tb/tb_per2apb_bridge.sv
// Bench for per2apb_bridge: transaction-level reference model plus directed scenarios.
// Build with PER2APB_TIMEOUT_EN defined to exercise the ACCESS-phase watchdog.
module tb_per2apb_bridge;

    localparam int TB_TIMEOUT = 4;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b0;
    logic        req     = 1'b0;
    logic [31:0] addr    = 32'h0;
    logic        we      = 1'b0;
    logic [31:0] wdata   = 32'h0;
    logic [3:0]  be      = 4'h0;
    logic [7:0]  id      = 8'h0;
    logic        gnt;
    logic        r_valid;
    logic        r_opc;
    logic [31:0] r_rdata;
    logic [7:0]  r_id;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic        pwrite;
    logic [3:0]  pstrb;
    logic        psel;
    logic        penable;
    logic [31:0] prdata  = 32'h0;
    logic        pready  = 1'b0;
    logic        pslverr = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int tb_cyc   = 0;
    int n_resp   = 0;

    // APB slave behaviour knobs: wait_cfg < 0 means never ready
    int          wait_cfg   = 0;
    logic [31:0] prdata_cfg = 32'h0;
    logic        slverr_cfg = 1'b0;
    int          acc_cnt    = 0;

    always #5 clk = ~clk;

    per2apb_bridge #(
        .APB_ADDR_WIDTH (32),
        .ID_WIDTH       (8),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .clk_i               (clk),
        .rst_ni              (rst_n),
        .per_slave_req_i     (req),
        .per_slave_add_i     (addr),
        .per_slave_we_i      (we),
        .per_slave_wdata_i   (wdata),
        .per_slave_be_i      (be),
        .per_slave_id_i      (id),
        .per_slave_gnt_o     (gnt),
        .per_slave_r_valid_o (r_valid),
        .per_slave_r_opc_o   (r_opc),
        .per_slave_r_rdata_o (r_rdata),
        .per_slave_r_id_o    (r_id),
        .paddr_o             (paddr),
        .pwdata_o            (pwdata),
        .pwrite_o            (pwrite),
        .pstrb_o             (pstrb),
        .psel_o              (psel),
        .penable_o           (penable),
        .prdata_i            (prdata),
        .pready_i            (pready),
        .pslverr_i           (pslverr)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: actual %0h required %0h", name, tb_cyc, act, exp);
        end
    endfunction

    always @(posedge clk) tb_cyc++;

    always @(negedge clk) begin
        if (r_valid === 1'b1) n_resp++;
    end

    // APB slave: ready after wait_cfg wait cycles of the ACCESS phase
    always @(posedge clk) begin
        #1;
        if (psel === 1'b1 && penable === 1'b1) begin
            pready = (wait_cfg >= 0) && (acc_cnt == wait_cfg);
            acc_cnt++;
        end else begin
            acc_cnt = 0;
            pready  = 1'b0;
        end
        prdata  = prdata_cfg;
        pslverr = slverr_cfg;
    end

    // Reference model: one transfer at a time, tracked by grant cycle and completion
    bit          m_busy     = 1'b0;
    bit          m_resp_due = 1'b0;
    bit          m_rst_prev = 1'b0;
    int          m_cyc      = 0;
    int          m_tgrant   = 0;
    int          m_waits    = 0;
    logic [31:0] m_addr     = 32'h0;
    logic [31:0] m_wdata    = 32'h0;
    logic [31:0] m_rdata    = 32'h0;
    logic        m_we       = 1'b0;
    logic        m_opc      = 1'b0;
    logic [3:0]  m_strb     = 4'h0;
    logic [7:0]  m_id       = 8'h0;

    always @(negedge clk) begin
        bit resp_now;
        bit exp_gnt;
        bit in_access;
        m_cyc++;
        resp_now   = m_resp_due;
        m_resp_due = 1'b0;
        if (m_rst_prev) begin
            m_busy   = 1'b0;
            resp_now = 1'b0;
        end
        m_rst_prev = !rst_n;
        in_access  = m_busy && ((m_cyc - m_tgrant) >= 2);
        exp_gnt    = rst_n && req && !m_busy && !resp_now;

        chk("gnt", gnt, exp_gnt);
        chk("psel", psel, m_busy);
        chk("penable", penable, in_access);
        chk("r_valid", r_valid, resp_now);
        if (m_busy) begin
            chk("paddr", paddr, m_addr);
            chk("pwrite", pwrite, m_we);
            chk("pwdata", pwdata, m_wdata);
            chk("pstrb", pstrb, m_strb);
        end
        if (resp_now) begin
            chk("r_id", r_id, m_id);
            chk("r_opc", r_opc, m_opc);
            chk("r_rdata", r_rdata, m_rdata);
        end

        if (in_access) begin
            if (pready) begin
                m_rdata    = m_we ? 32'h0 : prdata;
                m_opc      = pslverr;
                m_busy     = 1'b0;
                m_resp_due = 1'b1;
            end else begin
                m_waits++;
`ifdef PER2APB_TIMEOUT_EN
                if (m_waits == TB_TIMEOUT) begin
                    m_rdata    = 32'h0BAD_ACCE;
                    m_opc      = 1'b1;
                    m_busy     = 1'b0;
                    m_resp_due = 1'b1;
                end
`endif
            end
        end

        if (exp_gnt) begin
            m_busy   = 1'b1;
            m_tgrant = m_cyc;
            m_waits  = 0;
            m_addr   = addr;
            m_we     = we;
            m_wdata  = wdata;
            m_strb   = we ? be : 4'h0;
            m_id     = id;
        end
    end

    task automatic do_req(input logic [31:0] a, input logic w, input logic [31:0] d,
                          input logic [3:0] b, input logic [7:0] i, output int gcyc);
        bit granted;
        granted = 1'b0;
        gcyc    = -1;
        @(posedge clk); #1;
        req = 1'b1; addr = a; we = w; wdata = d; be = b; id = i;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (gnt === 1'b1) begin
                granted = 1'b1;
                gcyc    = tb_cyc;
                break;
            end
        end
        chk("req_granted", granted, 1'b1);
        @(posedge clk); #1;
        req = 1'b0;
    endtask

    task automatic wait_resp(input int limit, output bit found, output int pen,
                             output logic [31:0] rd, output logic opc, output logic [7:0] rid);
        found = 1'b0; pen = 0; rd = 32'h0; opc = 1'b0; rid = 8'h0;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (penable === 1'b1) pen++;
            if (r_valid === 1'b1) begin
                found = 1'b1;
                rd    = r_rdata;
                opc   = r_opc;
                rid   = r_id;
                break;
            end
        end
    endtask

    initial begin
        int          g1, g2, pen, resp_snap;
        bit          found;
        logic [31:0] rd;
        logic        opc;
        logic [7:0]  rid;

        // Reset with a pending request: no grant while rst_n is low
        req = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("gnt_in_reset", gnt, 1'b0);
        end
        chk("rst_psel", psel, 1'b0);
        chk("rst_penable", penable, 1'b0);
        chk("rst_pwrite", pwrite, 1'b0);
        chk("rst_paddr", paddr, 32'h0);
        chk("rst_pwdata", pwdata, 32'h0);
        chk("rst_pstrb", pstrb, 4'h0);
        chk("rst_r_valid", r_valid, 1'b0);
        chk("rst_r_opc", r_opc, 1'b0);
        chk("rst_r_rdata", r_rdata, 32'h0);
        chk("rst_r_id", r_id, 8'h0);
        @(posedge clk); #1;
        req   = 1'b0;
        rst_n = 1'b1;

        // 1: zero-wait write, cycle by cycle
        wait_cfg = 0;
        @(posedge clk); #1;
        req = 1'b1; addr = 32'h1A10_2004; we = 1'b1; wdata = 32'hCAFE_F00D; be = 4'hF; id = 8'h3C;
        @(negedge clk);
        chk("s1_gnt_c0", gnt, 1'b1);
        @(posedge clk); #1;
        req = 1'b0;
        @(negedge clk);
        chk("s1_psel_c1", psel, 1'b1);
        chk("s1_penable_c1", penable, 1'b0);
        @(negedge clk);
        chk("s1_psel_c2", psel, 1'b1);
        chk("s1_penable_c2", penable, 1'b1);
        chk("s1_pwrite_c2", pwrite, 1'b1);
        chk("s1_pstrb_c2", pstrb, 4'hF);
        chk("s1_paddr_c2", paddr, 32'h1A10_2004);
        chk("s1_pwdata_c2", pwdata, 32'hCAFE_F00D);
        @(negedge clk);
        chk("s1_r_valid_c3", r_valid, 1'b1);
        chk("s1_r_opc", r_opc, 1'b0);
        chk("s1_r_rdata", r_rdata, 32'h0);
        chk("s1_r_id", r_id, 8'h3C);

        // 2: read with five wait cycles
        wait_cfg = 5; prdata_cfg = 32'h1234_5678;
        do_req(32'h1A10_3008, 1'b0, 32'h55AA_55AA, 4'hF, 8'h11, g1);
        wait_resp(100, found, pen, rd, opc, rid);
        chk("s2_found", found, 1'b1);
        chk("s2_penable_cycles", pen, 6);
        chk("s2_r_rdata", rd, 32'h1234_5678);
        chk("s2_r_opc", opc, 1'b0);
        chk("s2_r_id", rid, 8'h11);

        // 3: read with slave error, strobes must stay zero
        wait_cfg = 1; prdata_cfg = 32'hDEAD_0001; slverr_cfg = 1'b1;
        do_req(32'h0000_0010, 1'b0, 32'h0, 4'hA, 8'h5A, g1);
        wait_resp(100, found, pen, rd, opc, rid);
        chk("s3_found", found, 1'b1);
        chk("s3_r_opc", opc, 1'b1);
        chk("s3_r_rdata", rd, 32'hDEAD_0001);
        chk("s3_penable_cycles", pen, 2);

        // 3b: write with slave error returns zero data
        wait_cfg = 0;
        do_req(32'h0000_0020, 1'b1, 32'h0F0F_0F0F, 4'h6, 8'h5B, g1);
        wait_resp(100, found, pen, rd, opc, rid);
        chk("s3b_r_opc", opc, 1'b1);
        chk("s3b_r_rdata", rd, 32'h0);
        slverr_cfg = 1'b0;

        // 4: second request raised during the first ACCESS is held off
        wait_cfg = 2; prdata_cfg = 32'hA5A5_0042;
        do_req(32'h0000_0100, 1'b1, 32'h1111_2222, 4'h3, 8'h21, g1);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (penable === 1'b1) break;
        end
        @(posedge clk); #1;
        req = 1'b1; addr = 32'h0000_0200; we = 1'b0; wdata = 32'h0; be = 4'hF; id = 8'h42;
        g2 = -1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (gnt === 1'b1) begin
                g2 = tb_cyc;
                break;
            end
        end
        chk("s4_gnt_gap", g2 - g1, 6);
        @(posedge clk); #1;
        req = 1'b0;
        wait_resp(100, found, pen, rd, opc, rid);
        chk("s4_found", found, 1'b1);
        chk("s4_r_id", rid, 8'h42);
        chk("s4_r_rdata", rd, 32'hA5A5_0042);

        // 5: reset in the middle of ACCESS aborts silently
        wait_cfg = -1;
        do_req(32'h0000_0300, 1'b0, 32'h0, 4'hF, 8'h77, g1);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (penable === 1'b1) break;
        end
        resp_snap = n_resp;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("s5_psel_after_rst", psel, 1'b0);
        chk("s5_penable_after_rst", penable, 1'b0);
        repeat (5) @(negedge clk);
        chk("s5_no_r_valid", n_resp, resp_snap);
        wait_cfg = 0;
        do_req(32'h0000_0304, 1'b1, 32'h7777_8888, 4'hC, 8'h78, g1);
        wait_resp(100, found, pen, rd, opc, rid);
        chk("s5_next_found", found, 1'b1);
        chk("s5_next_r_id", rid, 8'h78);
        chk("s5_next_r_opc", opc, 1'b0);

        // 6: slave never ready
        wait_cfg = -1;
        do_req(32'h0000_0400, 1'b0, 32'h0, 4'hF, 8'h99, g1);
`ifdef PER2APB_TIMEOUT_EN
        wait_resp(100, found, pen, rd, opc, rid);
        chk("s6_found", found, 1'b1);
        chk("s6_penable_cycles", pen, TB_TIMEOUT);
        chk("s6_r_opc", opc, 1'b1);
        chk("s6_r_rdata", rd, 32'h0BAD_ACCE);
        chk("s6_r_id", rid, 8'h99);
`else
        resp_snap = n_resp;
        wait_resp(1000, found, pen, rd, opc, rid);
        chk("s6_no_resp", found, 1'b0);
        chk("s6_resp_count", n_resp, resp_snap);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
`endif
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
